// File: rtl/lenet_pkg.sv
// Shared constants and helpers for the LeNet5 feature-extraction datapath.
package lenet_pkg;

  localparam int BIT_WIDTH_DEF  = 8;
  localparam int OUT_WIDTH_DEF  = 32;
  localparam int K_DEF          = 5;
  localparam int FRAC_SHIFT_DEF = 3;

  // Accumulator width: wide enough for the bias and for every full-range
  // product, plus the growth from summing K*K terms and a guard bit.
  function automatic int acc_width(input int bit_w, input int out_w, input int k);
    int base;
    base = (out_w > 2 * bit_w) ? out_w : 2 * bit_w;
    return base + $clog2(k * k) + 1;
  endfunction

  // Largest value representable in a signed field of out_w bits.
  function automatic longint sat_hi(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of out_w bits.
  function automatic longint sat_lo(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  localparam longint SAT_HI_DEF = sat_hi(OUT_WIDTH_DEF);
  localparam longint SAT_LO_DEF = sat_lo(OUT_WIDTH_DEF);

endpackage

// File: rtl/conv_row_mac.sv
// One window row times one filter row: K shifted products registered in the
// first stage, their sum registered in the second. Both stages move on en.
module conv_row_mac
  import lenet_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int K          = K_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int ACC_W      = acc_width(BIT_WIDTH_DEF, OUT_WIDTH_DEF, K_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [K*BIT_WIDTH-1:0]    pix_row,
  input  logic [K*BIT_WIDTH-1:0]    coef_row,
  output logic signed [ACC_W-1:0]   row_sum
);

  localparam int PW = 2 * BIT_WIDTH;

  logic signed [PW-1:0]    prod_full_s [K];
  logic signed [PW-1:0]    prod_sh_s   [K];
  logic signed [ACC_W-1:0] prod_d      [K];
  logic signed [ACC_W-1:0] prod_q      [K];
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] sum_q;

  // Form each floor-shifted product and the sum of the registered products.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < K; c++) begin
      prod_full_s[c] = PW'($signed(pix_row[BIT_WIDTH*c +: BIT_WIDTH]))
                     * PW'($signed(coef_row[BIT_WIDTH*c +: BIT_WIDTH]));
      prod_sh_s[c]   = prod_full_s[c] >>> FRAC_SHIFT;
      prod_d[c]      = {{(ACC_W-PW){prod_sh_s[c][PW-1]}}, prod_sh_s[c]};
      sum_d          = sum_d + prod_q[c];
    end
  end

  // Product stage and row-sum stage, frozen together while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < K; c++) begin
        prod_q[c] <= '0;
      end
      sum_q <= '0;
    end else if (en) begin
      for (int c = 0; c < K; c++) begin
        prod_q[c] <= prod_d[c];
      end
      sum_q <= sum_d;
    end
  end

  assign row_sum = sum_q;

endmodule

// File: rtl/conv_kxk_pipe.sv
// Pipelined KxK convolution: sliding column window, K row MACs, final
// bias / saturate / ReLU stage, valid/ready flow control with global stall.
module conv_kxk_pipe
  import lenet_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int K          = K_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coef_load,
  input  logic [K*K*BIT_WIDTH-1:0]   filter,
  input  logic [OUT_WIDTH-1:0]       bias,
  input  logic                       relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [K*BIT_WIDTH-1:0]     in_col,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       conv_out
);

  localparam int ACC_W = acc_width(BIT_WIDTH, OUT_WIDTH, K);
  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(K);
  localparam logic [CNT_W-1:0] KM1  = CNT_W'(K - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(OUT_WIDTH));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(OUT_WIDTH));

  // Window: win_q[c] is column c (0 = oldest), lane r inside the column.
  logic [K*BIT_WIDTH-1:0]   win_d [K];
  logic [K*BIT_WIDTH-1:0]   win_q [K];
  logic [K*BIT_WIDTH-1:0]   row_pix_s [K];
  logic signed [ACC_W-1:0]  row_sum_s [K];

  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic                     v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic                     out_valid_d, out_valid_q;
  logic [OUT_WIDTH-1:0]     conv_out_d, conv_out_q;

  logic [K*K*BIT_WIDTH-1:0] filter_d, filter_q;
  logic [OUT_WIDTH-1:0]     bias_d, bias_q;
  logic                     relu_d, relu_q;

  logic                     stall_s, advance_s, accept_s, complete_s;
  logic signed [ACC_W-1:0]  total_s;
  logic [OUT_WIDTH-1:0]     sat_s, res_s;

  assign stall_s    = out_valid_q && !out_ready;
  assign advance_s  = !stall_s;
  assign in_ready   = !stall_s && !coef_load;
  assign accept_s   = in_valid && in_ready;
  assign complete_s = (cnt_q == KM1) || (cnt_q == FULL);

  // Shift the window by one column on every accepted input.
  always_comb begin
    for (int c = 0; c < K; c++) begin
      win_d[c] = win_q[c];
    end
    if (accept_s) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[c] = win_q[c + 1];
      end
      win_d[K-1] = in_col;
    end else begin
      win_d[K-1] = win_q[K-1];
    end
  end

  // Window storage carries no reset; the fill counter guards its contents.
  always_ff @(posedge clk) begin
    for (int c = 0; c < K; c++) begin
      win_q[c] <= win_d[c];
    end
  end

  // Regroup the column-major window into per-lane rows for the row MACs.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      row_pix_s[r] = '0;
      for (int c = 0; c < K; c++) begin
        row_pix_s[r][BIT_WIDTH*c +: BIT_WIDTH] = win_q[c][BIT_WIDTH*r +: BIT_WIDTH];
      end
    end
  end

  for (genvar gr = 0; gr < K; gr++) begin : g_row
    conv_row_mac #(
      .BIT_WIDTH  (BIT_WIDTH),
      .K          (K),
      .FRAC_SHIFT (FRAC_SHIFT),
      .ACC_W      (ACC_W)
    ) u_row (
      .clk      (clk),
      .rst      (rst),
      .en       (advance_s),
      .pix_row  (row_pix_s[gr]),
      .coef_row (filter_q[BIT_WIDTH*K*gr +: BIT_WIDTH*K]),
      .row_sum  (row_sum_s[gr])
    );
  end

  // Shadow coefficient capture.
  always_comb begin
    if (coef_load) begin
      filter_d = filter;
      bias_d   = bias;
      relu_d   = relu_en;
    end else begin
      filter_d = filter_q;
      bias_d   = bias_q;
      relu_d   = relu_q;
    end
  end

  // Final stage arithmetic: row sums plus bias, saturation, then ReLU.
  always_comb begin
    total_s = {{(ACC_W-OUT_WIDTH){bias_q[OUT_WIDTH-1]}}, bias_q};
    for (int r = 0; r < K; r++) begin
      total_s = total_s + row_sum_s[r];
    end
    if (total_s > SAT_HI) begin
      sat_s = SAT_HI[OUT_WIDTH-1:0];
    end else if (total_s < SAT_LO) begin
      sat_s = SAT_LO[OUT_WIDTH-1:0];
    end else begin
      sat_s = total_s[OUT_WIDTH-1:0];
    end
    if (relu_q && sat_s[OUT_WIDTH-1]) begin
      res_s = '0;
    end else begin
      res_s = sat_s;
    end
  end

  // Fill counter and stage valid bits; a stall freezes every stage.
  always_comb begin
    cnt_d       = cnt_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    out_valid_d = out_valid_q;
    conv_out_d  = conv_out_q;
    if (accept_s) begin
      if (in_last) begin
        cnt_d = '0;
      end else if (cnt_q == FULL) begin
        cnt_d = FULL;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (advance_s) begin
      v1_d        = accept_s && complete_s;
      v2_d        = v1_q;
      v3_d        = v2_q;
      out_valid_d = v3_q;
      if (v3_q) begin
        conv_out_d = res_s;
      end else begin
        conv_out_d = conv_out_q;
      end
    end else begin
      v1_d        = v1_q;
      v2_d        = v2_q;
      v3_d        = v3_q;
      out_valid_d = out_valid_q;
      conv_out_d  = conv_out_q;
    end
  end

  // Control, coefficient and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      conv_out_q  <= '0;
      filter_q    <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      conv_out_q  <= conv_out_d;
      filter_q    <= filter_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
    end
  end

  assign out_valid = out_valid_q;
  assign conv_out  = conv_out_q;

endmodule

// File: tb/tb_conv_kxk_pipe.sv
// Self-checking bench for conv_kxk_pipe: coefficient/pixel vector table,
// scoreboard queue fed at column acceptance, hand sequences for latency,
// row boundaries, backpressure, mid-run reset and coefficient reload.
module tb_conv_kxk_pipe;

  localparam int K  = 5;
  localparam int BW = 8;
  localparam int OW = 8;
  localparam int FS = 3;

  logic               clk;
  logic               rst;
  logic               coef_load;
  logic [K*K*BW-1:0]  filter;
  logic [OW-1:0]      bias;
  logic               relu_en;
  logic               in_valid;
  logic               in_ready;
  logic [K*BW-1:0]    in_col;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [OW-1:0]      conv_out;

  conv_kxk_pipe #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .K(K), .FRAC_SHIFT(FS)) dut (
    .clk(clk), .rst(rst), .coef_load(coef_load), .filter(filter), .bias(bias),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .conv_out(conv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int tap;
    int bias;
    bit relu;
    int exp;
  } vec_t;

  vec_t vecs [9];
  int   tests;
  int   fails;
  int   results;
  int   exp_q [$];
  int   wm [K][K];
  int   tm [K][K];
  int   bias_m;
  bit   relu_m;
  int   cnt_m;
  bit   bp_mode;
  bit   hold_pend;
  int   hold_val;
  bit   use_tab;
  int   tab_exp;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int model_out();
    int s;
    s = bias_m;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        s = s + ((wm[r][c] * tm[r][c]) >>> FS);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (relu_m && s < 0) s = 0;
    return s;
  endfunction

  function automatic logic [K*K*BW-1:0] pack_filter();
    logic [K*K*BW-1:0] f;
    f = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        f[BW*(K*r+c) +: BW] = BW'(tm[r][c]);
    return f;
  endfunction

  function automatic logic [K*BW-1:0] mk_col(input int v);
    logic [K*BW-1:0] col;
    for (int r = 0; r < K; r++) col[BW*r +: BW] = BW'(v);
    return col;
  endfunction

  function automatic logic [K*BW-1:0] rand_col();
    logic [K*BW-1:0] col;
    for (int r = 0; r < K; r++) col[BW*r +: BW] = BW'(int'($urandom_range(0, 8)) - 4);
    return col;
  endfunction

  task automatic fill_taps(input int v);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        tm[r][c] = v;
  endtask

  task automatic apply_coef();
    filter    = pack_filter();
    bias      = OW'(bias_m);
    relu_en   = relu_m;
    coef_load = 1'b1;
    @(posedge clk); #1;
    coef_load = 1'b0;
  endtask

  task automatic send_col(input logic [K*BW-1:0] col, input logic last);
    int waited;
    bit ok;
    waited   = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_col   = col;
    in_last  = last;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_col: in_ready stayed 0 for %0d cycles, required 1", waited);
      in_valid = 1'b0;
    end else begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) wm[r][c] = wm[r][c+1];
        wm[r][K-1] = int'($signed(col[BW*r +: BW]));
      end
      if (cnt_m >= K - 1) exp_q.push_back(use_tab ? tab_exp : model_out());
      cnt_m = last ? 0 : ((cnt_m < K) ? cnt_m + 1 : K);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pend = 1'b0;
      end else begin
        check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready) && !coef_load));
        if (hold_pend) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'($signed(conv_out)), hold_val);
        end
        hold_pend = out_valid && !out_ready;
        hold_val  = int'($signed(conv_out));
        if (out_valid && out_ready) begin
          results++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %0d, expected no output", int'($signed(conv_out)));
          end else begin
            e = exp_q.pop_front();
            check("conv_out", int'($signed(conv_out)), e);
          end
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    vecs[0] = '{pix:    1, tap:   8, bias:    0, relu: 1'b0, exp:   25};
    vecs[1] = '{pix:   -1, tap:   8, bias:    0, relu: 1'b0, exp:  -25};
    vecs[2] = '{pix:   -1, tap:   8, bias:  100, relu: 1'b0, exp:   75};
    vecs[3] = '{pix:   -1, tap:   8, bias:    0, relu: 1'b1, exp:    0};
    vecs[4] = '{pix:  127, tap: 127, bias:    0, relu: 1'b0, exp:  127};
    vecs[5] = '{pix: -128, tap: 127, bias:    0, relu: 1'b0, exp: -128};
    vecs[6] = '{pix:   -1, tap:   7, bias:    0, relu: 1'b0, exp:  -25};
    vecs[7] = '{pix:    3, tap:   5, bias:  -30, relu: 1'b0, exp:   -5};
    vecs[8] = '{pix:    1, tap:   8, bias:  127, relu: 1'b0, exp:  127};

    tests = 0; fails = 0; results = 0;
    rst = 1'b0; coef_load = 1'b0; filter = '0; bias = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_col = '0; in_last = 1'b0; out_ready = 1'b1;
    bp_mode = 1'b0; hold_pend = 1'b0; hold_val = 0; use_tab = 1'b0; tab_exp = 0;
    cnt_m = 0; bias_m = 0; relu_m = 1'b0;
    fill_taps(0);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        wm[r][c] = 0;

    fork
      monitor_loop();
      ready_driver();
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_conv_out", int'(conv_out), 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Table of uniform windows: sign, floor, bias, ReLU, saturation.
    use_tab = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fill_taps(vecs[i].tap);
      bias_m = vecs[i].bias;
      relu_m = vecs[i].relu;
      apply_coef();
      tab_exp = vecs[i].exp;
      for (int j = 0; j < K; j++) send_col(mk_col(vecs[i].pix), (j == K - 1));
      wait_drain(50);
    end
    use_tab = 1'b0;

    // Latency: result appears exactly three cycles after the fifth column.
    fill_taps(8); bias_m = 0; relu_m = 1'b0;
    apply_coef();
    for (int j = 0; j < K - 1; j++) send_col(mk_col(2), 1'b0);
    send_col(mk_col(2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_early", int'(out_valid), 0);
    end
    @(negedge clk);
    check("latency_hit", int'(out_valid), 1);
    wait_drain(50);

    // Row boundary: 7 columns ending a row, then 5 more -> 4 results.
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        tm[r][c] = ((r * K + c) % 7) - 3;
    bias_m = 3;
    apply_coef();
    r0 = results;
    for (int j = 0; j < 7; j++) send_col(rand_col(), (j == 6));
    for (int j = 0; j < 5; j++) send_col(rand_col(), (j == 4));
    wait_drain(50);
    check("row_results", results - r0, 4);

    // Backpressure: 20 columns with random out_ready -> 16 ordered results.
    bp_mode = 1'b1;
    r0 = results;
    for (int j = 0; j < 20; j++) send_col(rand_col(), (j == 19));
    wait_drain(500);
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_results", results - r0, 16);

    // Reset with three results in flight.
    fill_taps(8); bias_m = 0; relu_m = 1'b0;
    apply_coef();
    for (int j = 0; j < 7; j++) send_col(mk_col(1), 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_conv_out", int'(conv_out), 0);
    exp_q.delete();
    cnt_m = 0;
    fill_taps(0); bias_m = 0; relu_m = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    r0 = results;
    for (int j = 0; j < K - 1; j++) send_col(mk_col(1), 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("reset_no_partial", results - r0, 0);
    send_col(mk_col(1), 1'b1);
    wait_drain(50);
    check("reset_first_result", results - r0, 1);

    // Coefficient reload colliding with a valid column.
    fill_taps(8); bias_m = 0; relu_m = 1'b0;
    apply_coef();
    r0 = results;
    for (int j = 0; j < K - 1; j++) send_col(mk_col(1), 1'b0);
    in_valid = 1'b1;
    in_col   = mk_col(1);
    in_last  = 1'b1;
    fill_taps(16);
    filter    = pack_filter();
    coef_load = 1'b1;
    @(negedge clk);
    check("coef_load_blocks", int'(in_ready), 0);
    @(posedge clk); #1;
    coef_load = 1'b0;
    send_col(mk_col(1), 1'b1);
    wait_drain(50);
    check("reload_results", results - r0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
